// File: rtl/crossbar_slave_mem.sv
// Word-addressed memory target for one crossbar slave half (addr[31]).
// Optional BOUND_CHECK_EN adds the err port and out-of-range handling.
module crossbar_slave_mem #(
  parameter logic SLAVE_ID = 1'b0,
  parameter int   AW       = 8,
  parameter int   LATENCY  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic        cmd,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata
`ifdef BOUND_CHECK_EN
  ,
  output logic        err
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ACK
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t        state_q;
  state_t        state_d;
  logic          accept;
  logic          done;
  logic [3:0]    cnt_q;
  logic [AW-1:0] idx_q;
  logic          cmd_q;
  logic [31:0]   wdata_q;
  logic          wr_ok;
  logic [31:0]   rd_word;
  logic [31:0]   mem [2**AW];

`ifdef BOUND_CHECK_EN
  logic oor_q;
  logic in_range;
  logic unused_addr;

  assign in_range = (addr[31] == SLAVE_ID) &&
                    (addr[30:AW+2] == '0);
  assign unused_addr = ^addr[1:0];
  assign wr_ok    = !oor_q;
  assign rd_word  = oor_q ? 32'hDEAD_BEEF : mem[idx_q];
  assign err      = ack & oor_q;

  // Range verdict is taken with the rest of the request
  always_ff @(posedge clk) begin
    if (accept) begin
      oor_q <= !in_range;
    end
  end
`else
  logic unused_addr;

  assign unused_addr = ^{addr[31:AW+2], addr[1:0], SLAVE_ID};
  assign wr_ok    = 1'b1;
  assign rd_word  = mem[idx_q];
`endif

  assign ack = (state_q == ACK);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and single-cycle strobes
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          state_d = BUSY;
          accept  = 1'b1;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = ACK;
          done    = 1'b1;
        end
      end
      ACK: begin
        if (!req) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Wait-state counter, loaded on accept
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else if (accept) begin
      cnt_q <= CNT_INIT;
    end else if (state_q == BUSY && cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // Capture request; later input changes are ignored
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q   <= addr[AW+1:2];
      cmd_q   <= cmd;
      wdata_q <= wdata;
    end
  end

  // Read data updates only when a read completes
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= 32'd0;
    end else if (done && !cmd_q) begin
      rdata <= rd_word;
    end
  end

  // Storage array is never reset; reset aborts a pending write
  always_ff @(posedge clk) begin
    if (!rst && done && cmd_q && wr_ok) begin
      mem[idx_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_crossbar_slave_mem.sv
// Scoreboard bench for crossbar_slave_mem plus latency sweep instances.
// Honours BOUND_CHECK_EN the same way as the design.
module tb_crossbar_slave_mem;

  typedef struct {
    logic [31:0] rdata;
    bit          err;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [31:0] addr = '0;
  logic        cmd = 1'b0;
  logic [31:0] wdata = '0;
  logic        ack;
  logic [31:0] rdata;
`ifdef BOUND_CHECK_EN
  logic        err;
  logic [2:0]  sw_err;
`endif

  logic [2:0]  sw_req = '0;
  logic [2:0]  sw_cmd = '0;
  logic [2:0]  sw_ack;
  logic [31:0] sw_addr [3];
  logic [31:0] sw_wdata [3];
  logic [31:0] sw_rdata [3];

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  exp_t        sbq [$];
  logic [31:0] mem_m [int];
  logic [31:0] last_rd = '0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  crossbar_slave_mem #(
    .SLAVE_ID(1'b0),
    .AW(8),
    .LATENCY(2)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .addr(addr),
    .cmd(cmd),
    .wdata(wdata),
    .ack(ack),
    .rdata(rdata)
`ifdef BOUND_CHECK_EN
    ,
    .err(err)
`endif
  );

  for (genvar g = 0; g < 3; g++) begin : g_sw
    crossbar_slave_mem #(
      .SLAVE_ID(1'b0),
      .AW(8),
      .LATENCY(g == 0 ? 1 : (g == 1 ? 4 : 15))
    ) u_sw (
      .clk(clk),
      .rst(rst),
      .req(sw_req[g]),
      .addr(sw_addr[g]),
      .cmd(sw_cmd[g]),
      .wdata(sw_wdata[g]),
      .ack(sw_ack[g]),
      .rdata(sw_rdata[g])
`ifdef BOUND_CHECK_EN
      ,
      .err(sw_err[g])
`endif
    );
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  function automatic bit m_oor(input logic [31:0] a);
`ifdef BOUND_CHECK_EN
    return (a[31] != 1'b0) ||
           ((a & 32'h7FFF_FFFF) >= 32'h0000_0400);
`else
    return (a == 32'hFFFF_FFFF) && 1'b0;
`endif
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a >> 2) % 32'd256);
  endfunction

  // Monitor: pop an expectation on each ack rise, then watch rdata hold
  logic [31:0] cur_rd = '0;
  bit          in_ack = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      in_ack = 1'b0;
    end else if (ack === 1'b1) begin
      if (!in_ack) begin
        in_ack = 1'b1;
        if (sbq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_ack: got ack=1 required no ack, cycle %0d",
                   cyc);
          cur_rd = rdata;
        end else begin
          e = sbq.pop_front();
          check("rdata", rdata, e.rdata);
          check("latency", 32'(cyc - e.acc), 32'd2);
`ifdef BOUND_CHECK_EN
          check("err", {31'd0, err}, {31'd0, e.err});
`endif
          cur_rd = e.rdata;
        end
      end else begin
        check("rdata_hold", rdata, cur_rd);
      end
    end else begin
      in_ack = 1'b0;
    end
  end

  task automatic start(input logic c,
                       input logic [31:0] a,
                       input logic [31:0] d);
    exp_t e;
    addr = a;
    cmd = c;
    wdata = d;
    req = 1'b1;
    e.acc = cyc + 1;
    e.err = m_oor(a);
    if (c) begin
      if (!m_oor(a)) mem_m[m_idx(a)] = d;
      e.rdata = last_rd;
    end else begin
      if (m_oor(a)) e.rdata = 32'hDEAD_BEEF;
      else if (mem_m.exists(m_idx(a))) e.rdata = mem_m[m_idx(a)];
      else e.rdata = 32'hx;
      last_rd = e.rdata;
    end
    sbq.push_back(e);
  endtask

  task automatic wait_ack();
    int n = 0;
    while (ack !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (ack !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL ack_timeout: got no ack required ack within 40 cycles");
    end
  endtask

  task automatic txn(input logic c,
                     input logic [31:0] a,
                     input logic [31:0] d,
                     input int hold,
                     input bit garble);
    start(c, a, d);
    wait_ack();
    for (int i = 0; i < hold; i++) begin
      if (garble) begin
        addr = $urandom;
        wdata = $urandom;
        cmd = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      #1;
    end
    req = 1'b0;
    @(posedge clk);
    #1;
    check("ack_fall", {31'd0, ack}, 32'd0);
  endtask

  task automatic early_drop(input logic c,
                            input logic [31:0] a,
                            input logic [31:0] d);
    start(c, a, d);
    @(posedge clk);
    #1;
    req = 1'b0;
    wait_ack();
    @(posedge clk);
    #1;
    check("ack_one_cycle", {31'd0, ack}, 32'd0);
  endtask

  task automatic sw_wait(input int k);
    int n = 0;
    while (sw_ack[k] !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sw_ack[k] !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL sw_timeout: got no ack required ack, unit %0d", k);
    end
  endtask

  task automatic sweep(input int k, input int lat);
    int acc;
    int prev;
    logic [31:0] d;
    d = 32'h0B00_0000 + 32'(k);
    sw_addr[k] = 32'h40;
    sw_wdata[k] = d;
    sw_cmd[k] = 1'b1;
    sw_req[k] = 1'b1;
    acc = cyc + 1;
    sw_wait(k);
    check("sw_wr_latency", 32'(cyc - acc), 32'(lat));
    sw_req[k] = 1'b0;
    @(posedge clk);
    #1;
    check("sw_ack_fall", {31'd0, sw_ack[k]}, 32'd0);
    prev = 0;
    for (int i = 0; i < 3; i++) begin
      sw_cmd[k] = 1'b0;
      sw_req[k] = 1'b1;
      acc = cyc + 1;
      if (i > 0) check("sw_period", 32'(acc - prev), 32'(lat + 2));
      prev = acc;
      sw_wait(k);
      check("sw_rd_latency", 32'(cyc - acc), 32'(lat));
      check("sw_rdata", sw_rdata[k], d);
      sw_req[k] = 1'b0;
      @(posedge clk);
      #1;
      check("sw_ack_fall", {31'd0, sw_ack[k]}, 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish required finish by 500us");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        c;
    logic [31:0] a;
    logic [31:0] r;
    for (int i = 0; i < 3; i++) begin
      sw_addr[i] = '0;
      sw_wdata[i] = '0;
    end
    // Reset held two cycles with req asserted
    rst = 1'b1;
    req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("rst_ack", {31'd0, ack}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
    end
    rst = 1'b0;
    req = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_ack", {31'd0, ack}, 32'd0);

    // Write then read back
    txn(1'b1, 32'h10, 32'hCAFE_0001, 0, 1'b0);
    txn(1'b0, 32'h10, 32'h0, 0, 1'b0);

    // Long hold with input churn during ack
    txn(1'b0, 32'h10, 32'h0, 5, 1'b1);
    txn(1'b0, 32'h10, 32'h0, 0, 1'b0);

    // Reset during the wait states aborts a write
    txn(1'b1, 32'h20, 32'h0000_AAAA, 0, 1'b0);
    addr = 32'h20;
    cmd = 1'b1;
    wdata = 32'h0000_1234;
    req = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    last_rd = 32'd0;
    check("abort_rdata", rdata, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("abort_no_ack", {31'd0, ack}, 32'd0);
    end
    txn(1'b0, 32'h20, 32'h0, 0, 1'b0);

    // Aliasing or out-of-range access
    txn(1'b1, 32'h0, 32'h0000_1111, 0, 1'b0);
    txn(1'b1, 32'h400, 32'h0000_5555, 0, 1'b0);
    txn(1'b0, 32'h400, 32'h0, 0, 1'b0);
    txn(1'b0, 32'h0, 32'h0, 0, 1'b0);

    // req withdrawn during wait states
    early_drop(1'b0, 32'h10, 32'h0);
    early_drop(1'b1, 32'h18, 32'h0000_7777);
    txn(1'b0, 32'h18, 32'h0, 0, 1'b0);

    // Fill the random address pool
    for (int i = 0; i < 8; i++) begin
      txn(1'b1, 32'(i * 4), $urandom, 0, 1'b0);
    end

    // Randomised traffic
    for (int i = 0; i < 60; i++) begin
      c = 1'($urandom_range(0, 1));
      a = 32'($urandom_range(0, 7)) * 32'd4 + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        r = $urandom;
        a = a | (r & 32'hFFFF_FC00);
      end
      if ($urandom_range(0, 7) == 0) early_drop(c, a, $urandom);
      else txn(c, a, $urandom, $urandom_range(0, 3),
               1'($urandom_range(0, 1)));
    end

    // Latency sweep and back-to-back period
    sweep(0, 1);
    sweep(1, 4);
    sweep(2, 15);

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", 32'(sbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
